// File: rtl/spi_target_pkg.sv
// rtl/spi_target_pkg.sv - shared types and constants for the SPI register target
package spi_target_pkg;

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  localparam int         CMD_WR_BIT       = 7;
  localparam int         FRAME_BITS       = 8;
  localparam logic [7:0] ID_VALUE_DEFAULT = 8'hA5;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - two-flop synchronizer with registered edge detect
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic PCLK,
  input  logic resetn,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  // sr[0..1] synchronize, sr[2] holds the previous synchronized level
  logic [2:0] sr;

  always_ff @(posedge PCLK or posedge resetn) begin
    if (resetn) sr <= {3{RESET_VAL}};
    else        sr <= {sr[1:0], din};
  end

  assign level = sr[1];
  assign rise  = sr[1] & ~sr[2];
  assign fall  = ~sr[1] & sr[2];

endmodule

// File: rtl/spi_target.sv
// rtl/spi_target.sv - oversampled SPI target serving a 16x8 register file
module spi_target
  import spi_target_pkg::*;
#(
  parameter int         DEPTH    = 16,
  parameter logic [7:0] ID_VALUE = ID_VALUE_DEFAULT,
  localparam int        IW       = $clog2(DEPTH)
) (
  input  logic          PCLK,
  input  logic          resetn,
  input  logic          SCLK,
  input  logic          CS_n,
  input  logic          MOSI,
  output logic          MISO,
  output logic          MISO_oe,
  output logic          wr_stb,
  output logic [IW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          frame_err
);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_lvl;
  logic unused_sclk_level, unused_cs_level, unused_mosi_rise, unused_mosi_fall;

  spi_sync_edge #(.RESET_VAL(1'b1)) u_sclk (
    .PCLK(PCLK), .resetn(resetn), .din(SCLK),
    .level(unused_sclk_level), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.RESET_VAL(1'b1)) u_cs (
    .PCLK(PCLK), .resetn(resetn), .din(CS_n),
    .level(unused_cs_level), .rise(cs_rise), .fall(cs_fall));
  spi_sync_edge #(.RESET_VAL(1'b0)) u_mosi (
    .PCLK(PCLK), .resetn(resetn), .din(MOSI),
    .level(mosi_lvl), .rise(unused_mosi_rise), .fall(unused_mosi_fall));

  state_t        state, state_d;
  logic [2:0]    bit_cnt;
  logic [7:0]    rx_shift, rx_next, tx_shift;
  logic          miso_q, cmd_wr;
  logic [IW-1:0] cmd_idx;
  logic [7:0]    regs [DEPTH];
  logic          last_bit, rx_step, tx_step, latch_cmd, commit, abort, clr_cnt;

  assign last_bit = (bit_cnt == 3'(FRAME_BITS - 1));
  assign rx_next  = {mosi_lvl, rx_shift[7:1]};

  always_ff @(posedge PCLK or posedge resetn) begin
    if (resetn) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d   = state;
    rx_step   = 1'b0;
    tx_step   = 1'b0;
    latch_cmd = 1'b0;
    commit    = 1'b0;
    abort     = 1'b0;
    clr_cnt   = 1'b0;
    case (state)
      IDLE: if (cs_fall) begin
        state_d = CMD;
        clr_cnt = 1'b1;
      end
      CMD: begin
        if (cs_rise) begin
          state_d = IDLE;
          abort   = 1'b1;
        end else if (sclk_rise) begin
          rx_step = 1'b1;
          if (last_bit) begin
            latch_cmd = 1'b1;
            state_d   = DATA;
          end
        end
      end
      DATA: begin
        // the final data bit beats a coincident CS_n release
        if (sclk_rise && last_bit) begin
          rx_step = 1'b1;
          commit  = cmd_wr;
          state_d = cs_rise ? IDLE : DONE;
        end else if (cs_rise) begin
          state_d = IDLE;
          abort   = 1'b1;
        end else begin
          rx_step = sclk_rise;
          tx_step = sclk_fall && !cmd_wr;
        end
      end
      DONE: if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge resetn) begin
    if (resetn) begin
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      miso_q    <= 1'b0;
      cmd_wr    <= 1'b0;
      cmd_idx   <= '0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= (i == 0) ? ID_VALUE : 8'h00;
    end else begin
      wr_stb    <= commit;
      frame_err <= abort;
      if (clr_cnt)      bit_cnt <= '0;
      else if (rx_step) bit_cnt <= bit_cnt + 3'd1;
      if (rx_step) rx_shift <= rx_next;
      if (latch_cmd) begin
        cmd_wr   <= rx_next[CMD_WR_BIT];
        cmd_idx  <= rx_next[IW-1:0];
        tx_shift <= regs[rx_next[IW-1:0]];
        miso_q   <= 1'b0;
      end
      if (tx_step) begin
        miso_q   <= tx_shift[0];
        tx_shift <= {1'b0, tx_shift[7:1]};
      end
      if (commit) begin
        wr_addr <= cmd_idx;
        wr_data <= rx_next;
        // register 0 holds the ID and never takes write data
        if (cmd_idx != '0) regs[cmd_idx] <= rx_next;
      end
    end
  end

  assign MISO_oe = ((state == DATA) || (state == DONE)) && !cmd_wr;
  assign MISO    = MISO_oe & miso_q;

endmodule

// File: tb/tb_spi_target.sv
// tb/tb_spi_target.sv - directed self-checking bench for spi_target
module tb_spi_target;

  logic       PCLK = 1'b0;
  logic       resetn = 1'b1;
  logic       SCLK = 1'b1;
  logic       CS_n = 1'b1;
  logic       MOSI = 1'b0;
  logic       MISO, MISO_oe, wr_stb, frame_err;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  int total = 0;
  int bad = 0;
  int stb_cnt = 0;
  int ferr_cnt = 0;

  spi_target dut (
    .PCLK(PCLK), .resetn(resetn), .SCLK(SCLK), .CS_n(CS_n), .MOSI(MOSI),
    .MISO(MISO), .MISO_oe(MISO_oe), .wr_stb(wr_stb), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_err(frame_err));

  always #5 PCLK = ~PCLK;

  always @(negedge PCLK) begin
    if (wr_stb)    stb_cnt++;
    if (frame_err) ferr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  // bits go out LSB first; rx captures MISO just before each SCLK rise
  task automatic frame(input logic [23:0] tx, input int n, input bit keep_cs,
                       output logic [23:0] rx);
    rx   = '0;
    CS_n = 1'b0;
    wait_clk(6);
    for (int i = 0; i < n; i++) begin
      SCLK = 1'b0;
      MOSI = tx[i];
      wait_clk(10);
      rx[i] = MISO;
      SCLK  = 1'b1;
      wait_clk(10);
    end
    if (!keep_cs) begin
      CS_n = 1'b1;
      MOSI = 1'b0;
      wait_clk(10);
    end
  endtask

  task automatic read_reg(input logic [3:0] idx, output logic [7:0] d);
    logic [23:0] rx;
    frame({16'h0000, 4'h0, idx}, 16, 1'b0, rx);
    d = rx[15:8];
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_miso"},    MISO, 0);
    chk({tag, "_miso_oe"}, MISO_oe, 0);
    chk({tag, "_wr_stb"},  wr_stb, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_ferr"},    frame_err, 0);
  endtask

  initial begin
    logic [23:0] rx;
    logic [7:0]  d;
    int          s0, f0;

    wait_clk(10);
    resetn = 1'b0;
    wait_clk(5);
    chk_reset_outputs("rst");

    read_reg(4'h0, d);
    chk("id_read", d, 8'hA5);
    chk("id_read_stb", stb_cnt, 0);

    s0 = stb_cnt; f0 = ferr_cnt;
    frame({8'h00, 8'h55, 8'h85}, 16, 1'b0, rx);
    chk("wr5_stb", stb_cnt - s0, 1);
    chk("wr5_ferr", ferr_cnt - f0, 0);
    chk("wr5_addr", wr_addr, 4'h5);
    chk("wr5_data", wr_data, 8'h55);
    read_reg(4'h5, d);
    chk("rd5", d, 8'h55);
    chk("rd5_oe_after", MISO_oe, 0);

    s0 = stb_cnt;
    frame({8'h00, 8'hFF, 8'h80}, 16, 1'b0, rx);
    chk("wr0_stb", stb_cnt - s0, 1);
    chk("wr0_addr", wr_addr, 4'h0);
    chk("wr0_data", wr_data, 8'hFF);
    read_reg(4'h0, d);
    chk("rd0_ro", d, 8'hA5);

    s0 = stb_cnt; f0 = ferr_cnt;
    frame({8'h00, 8'h3C, 8'h83}, 12, 1'b0, rx);
    chk("abort_ferr", ferr_cnt - f0, 1);
    chk("abort_stb", stb_cnt - s0, 0);
    chk("abort_oe", MISO_oe, 0);
    read_reg(4'h3, d);
    chk("abort_rd3", d, 8'h00);

    s0 = stb_cnt; f0 = ferr_cnt;
    frame({8'hFF, 8'h12, 8'h87}, 24, 1'b0, rx);
    chk("ovr_stb", stb_cnt - s0, 1);
    chk("ovr_ferr", ferr_cnt - f0, 0);
    chk("ovr_addr", wr_addr, 4'h7);
    chk("ovr_data", wr_data, 8'h12);
    read_reg(4'h7, d);
    chk("ovr_rd7", d, 8'h12);

    s0 = stb_cnt;
    frame({8'h00, 8'h99, 8'h82}, 10, 1'b1, rx);
    resetn = 1'b1;
    wait_clk(2);
    chk_reset_outputs("mid_rst");
    CS_n = 1'b1;
    SCLK = 1'b1;
    MOSI = 1'b0;
    wait_clk(5);
    resetn = 1'b0;
    wait_clk(5);
    chk("mid_rst_stb", stb_cnt - s0, 0);
    read_reg(4'h2, d);
    chk("mid_rst_rd2", d, 8'h00);
    read_reg(4'h7, d);
    chk("mid_rst_rd7", d, 8'h00);

    s0 = stb_cnt;
    frame({8'h00, 8'h99, 8'h82}, 16, 1'b0, rx);
    chk("wr2_stb", stb_cnt - s0, 1);
    chk("wr2_addr", wr_addr, 4'h2);
    chk("wr2_data", wr_data, 8'h99);
    read_reg(4'h2, d);
    chk("rd2", d, 8'h99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
